wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline interface: takes the latched MEM/WB outputs, performs the writeback select and commits results into the 32-entry integer register file.
- Provides two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Provides a writeback-data output for the forwarding unit and a committed-write counter for debug/perf.

---
 rtl/wb_regfile.sv | 127 ++++++++++++
 tb/tb_wb_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32-entry integer register file.
// It selects the writeback data from the MEM/WB latch and commits it to the
// register array. Two combinational read ports feed the ID stage, and a write
// that is pending in the current cycle is bypassed straight to those ports.
// A free-running counter records how many register writes have committed.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ALU_Res_i,
    input  logic [DATA_W-1:0] Read_Data_i,
    input  logic [ADDR_W-1:0] RdAddr_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WB_Data_o,
    output logic              WB_Valid_o,
    output logic [CNT_W-1:0]  Commit_Cnt_o
);

    localparam int NREG = 2 ** ADDR_W;

    // Entry 0 is kept in the array so that reads can use a plain index. It is
    // cleared by reset and is never written, because a commit requires a
    // nonzero destination address.
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [DATA_W-1:0] wb_data_s;
    logic              wb_valid_s;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;

    // Writeback select, and the commit qualifier that excludes x0 and bubbles.
    always_comb begin
        wb_data_s  = {DATA_W{1'b0}};
        wb_valid_s = 1'b0;
        if (MemToReg_i) begin
            wb_data_s = Read_Data_i;
        end else begin
            wb_data_s = ALU_Res_i;
        end
        if (RegWrite_i && (RdAddr_i != {ADDR_W{1'b0}})) begin
            wb_valid_s = 1'b1;
        end else begin
            wb_valid_s = 1'b0;
        end
    end

    // Next state of the register array. Only the addressed entry changes, and
    // only on a valid commit. When RegWrite_i is low, RdAddr_i has no effect.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (wb_valid_s && (RdAddr_i == ADDR_W'(i))) begin
                regs_d[i] = wb_data_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Next state of the commit counter. It wraps naturally at 2**CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (wb_valid_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Register array and counter state. An asynchronous reset clears both and
    // discards any write that is pending on the next edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    // Read port 1 has this priority: x0 first, then the same-cycle bypass,
    // then the register array.
    always_comb begin
        rs1_data_s = {DATA_W{1'b0}};
        if (RS1addr_i == {ADDR_W{1'b0}}) begin
            rs1_data_s = {DATA_W{1'b0}};
        end else if (wb_valid_s && (RS1addr_i == RdAddr_i)) begin
            rs1_data_s = wb_data_s;
        end else begin
            rs1_data_s = regs_q[RS1addr_i];
        end
    end

    // Read port 2 uses the same priority as port 1 but is fully independent.
    always_comb begin
        rs2_data_s = {DATA_W{1'b0}};
        if (RS2addr_i == {ADDR_W{1'b0}}) begin
            rs2_data_s = {DATA_W{1'b0}};
        end else if (wb_valid_s && (RS2addr_i == RdAddr_i)) begin
            rs2_data_s = wb_data_s;
        end else begin
            rs2_data_s = regs_q[RS2addr_i];
        end
    end

    assign RS1data_o    = rs1_data_s;
    assign RS2data_o    = rs2_data_s;
    assign WB_Data_o    = wb_data_s;
    assign WB_Valid_o   = wb_valid_s;
    assign Commit_Cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. The stimulus side drives one vector per
// cycle and pushes the expected outputs, computed from a plain array model,
// into a queue. The monitor pops that queue on each falling edge and compares
// the DUT outputs against it.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu, rdd;
    logic [AW-1:0] rd, a1, a2;
    logic          m2r, we;
    logic [DW-1:0] r1_o, r2_o, wbd_o;
    logic          wbv_o;
    logic [CW-1:0] cnt_o;

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .ALU_Res_i(alu), .Read_Data_i(rdd),
        .RdAddr_i(rd), .MemToReg_i(m2r), .RegWrite_i(we),
        .RS1addr_i(a1), .RS2addr_i(a2), .RS1data_o(r1_o), .RS2data_o(r2_o),
        .WB_Data_o(wbd_o), .WB_Valid_o(wbv_o), .Commit_Cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [DW-1:0] r1, r2, wbd;
        logic          wbv;
        int            cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: what the register file should contain, and the number
    // of commits so far (the counter is expected to read this modulo 2**CW).
    logic [DW-1:0] mdl [32];
    int            mdl_cnt;

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a,
                                               input logic v,
                                               input logic [DW-1:0] d);
        if (a == 5'd0) return 32'd0;
        if (v && a == rd) return d;
        return mdl[a];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl_cnt = 0;
    endtask

    // Pushes the expected outputs for the inputs currently being driven.
    task automatic push_exp(input string nm);
        exp_t          e;
        logic [DW-1:0] d;
        logic          v;
        d     = m2r ? rdd : alu;
        v     = we && (rd != 5'd0);
        e.nm  = nm;
        e.wbd = d;
        e.wbv = v;
        e.r1  = mdl_read(a1, v, d);
        e.r2  = mdl_read(a2, v, d);
        e.cnt = mdl_cnt % (1 << CW);
        q.push_back(e);
    endtask

    // Drives one vector just after a rising edge, records its expectation, and
    // applies the commit to the model that the next edge should perform.
    task automatic apply(input string nm, input logic w, input logic m,
                         input logic [AW-1:0] d_a, input logic [DW-1:0] al,
                         input logic [DW-1:0] ld, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2);
        we = w; m2r = m; rd = d_a; alu = al; rdd = ld; a1 = s1; a2 = s2;
        push_exp(nm);
        if (!rst && we && rd != 5'd0) begin
            mdl[rd] = m2r ? rdd : alu;
            mdl_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each falling edge, compares the DUT outputs against the
    // oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (r1_o !== e.r1) begin
                n_err++;
                $display("FAIL %s rs1: got %h want %h", e.nm, r1_o, e.r1);
            end
            if (r2_o !== e.r2) begin
                n_err++;
                $display("FAIL %s rs2: got %h want %h", e.nm, r2_o, e.r2);
            end
            if (wbd_o !== e.wbd) begin
                n_err++;
                $display("FAIL %s wb_data: got %h want %h", e.nm, wbd_o, e.wbd);
            end
            if (wbv_o !== e.wbv) begin
                n_err++;
                $display("FAIL %s wb_valid: got %b want %b", e.nm, wbv_o, e.wbv);
            end
            if (cnt_o !== CW'(e.cnt)) begin
                n_err++;
                $display("FAIL %s commit_cnt: got %0d want %0d", e.nm, cnt_o, e.cnt);
            end
        end
    end

    // Watchdog that ends the run if the stimulus process ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] ra;
    logic [DW-1:0] rv;

    initial begin
        rst = 1'b1; we = 1'b0; m2r = 1'b0; rd = 5'd0; alu = 32'd0; rdd = 32'd0;
        a1 = 5'd0; a2 = 5'd0;
        mdl_clear();
        @(posedge clk); #1;
        apply("reset_hold", 1'b0, 1'b0, 5'd4, 32'h55, 32'h66, 5'd4, 5'd31);
        rst = 1'b0;

        // ALU writeback, then read it back.
        apply("alu_wr", 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 5'd1, 5'd2);
        apply("alu_rd", 1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd0);

        // Load writeback with a same-cycle bypass on both ports.
        apply("ld_bypass", 1'b1, 1'b1, 5'd7, 32'h0BAD_0BAD, 32'hCAFE_F00D, 5'd7, 5'd7);
        apply("ld_after", 1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7);

        // Writes to x0 are dropped and do not count as commits.
        apply("x0_wr", 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        apply("x0_after", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5);

        // A disabled write must leave the register unchanged.
        apply("x3_pre", 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++)
            apply("x3_dis", 1'b0, 1'b0, 5'd3, 32'h22, 32'h0, 5'd3, 5'd3);

        // Randomized traffic. Read addresses are biased toward the destination
        // so that the bypass path is exercised often.
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] d, s1, s2;
            d  = AW'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, 31));
            apply("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  d, $urandom, $urandom, s1, s2);
        end

        // Assert reset mid-cycle while a write is pending; that write must be
        // discarded.
        we = 1'b1; m2r = 1'b0; rd = 5'd9; alu = 32'hA5A5_A5A5; a1 = 5'd10; a2 = 5'd9;
        #2;
        rst = 1'b1;
        mdl_clear();
        a2 = 5'd11;
        push_exp("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i < 32; i++)
            apply("rst_clear", 1'b0, 1'b0, 5'd9, 32'h0, 32'h0, AW'(i), AW'(32 - i));

        // Seventeen commits wrap a 4-bit counter back to 1. Then read all of
        // the written values back.
        for (int i = 1; i <= 17; i++) begin
            ra = AW'(i % 32);
            rv = $urandom;
            apply("wrap_wr", 1'b1, 1'($urandom_range(0, 1)), ra, rv, ~rv, ra, 5'd1);
        end
        for (int i = 1; i <= 17; i++)
            apply("wrap_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, AW'(i), AW'(18 - i));

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
